// File: rtl/dual_port_fifo_pkg.sv
// Shared constants for the dual-port FIFO: default widths and the count-width rule.
package dual_port_fifo_pkg;

  localparam int DEF_DATA_WIDTH   = 6;
  localparam int DEF_ADDR_WIDTH   = 3;
  localparam int DEF_ALMOST_FULL  = 6;
  localparam int DEF_ALMOST_EMPTY = 2;

  // One extra count bit separates "full" (count == depth) from "empty".
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/dual_port_memory.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
// A synthesized netlist (dual_port_memory_synth) keeps this exact port list.
module dual_port_memory #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int MEM_SIZE   = 2 ** ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE];

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dual_port_fifo.sv
// Synchronous FIFO over dual_port_memory with occupancy count and threshold flags.
// Define FIFO_ERROR_EN to build the sticky overflow/underflow flags (tied 0 otherwise).
module dual_port_fifo
  import dual_port_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int ALMOST_FULL  = DEF_ALMOST_FULL,
  parameter int ALMOST_EMPTY = DEF_ALMOST_EMPTY
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPush,
  input  logic                  iPop,
  input  logic [DATA_WIDTH-1:0] iDataIn,
  output logic [DATA_WIDTH-1:0] oDataOut,
  output logic                  oValid,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAlmostFull,
  output logic                  oAlmostEmpty,
  output logic                  oOverflow,
  output logic                  oUnderflow
);

  localparam int CW    = cnt_width(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  localparam logic [CW-1:0]         CNT_ONE = CW'(1);
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_C    = CW'(ALMOST_FULL);
  localparam logic [CW-1:0]         AE_C    = CW'(ALMOST_EMPTY);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  push_ok, pop_ok;

  // Requests in the reset cycle are ignored; acceptance uses the registered flags.
  assign push_ok = iPush && !oFull  && !Reset;
  assign pop_ok  = iPop  && !oEmpty && !Reset;

  always_comb begin
    count_nxt = oCount;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = oCount + CNT_ONE;
      2'b01:   count_nxt = oCount - CNT_ONE;
      default: count_nxt = oCount;
    endcase
  end

  // Flags follow count_nxt so they line up with oCount after each edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      oCount       <= '0;
      oFull        <= 1'b0;
      oEmpty       <= 1'b1;
      oAlmostFull  <= 1'b0;
      oAlmostEmpty <= 1'b1;
      oValid       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      oCount       <= count_nxt;
      oFull        <= (count_nxt == DEPTH_C);
      oEmpty       <= (count_nxt == '0);
      oAlmostFull  <= (count_nxt >= AF_C);
      oAlmostEmpty <= (count_nxt <= AE_C);
      oValid       <= pop_ok;
    end
  end

  dual_port_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (DEPTH - 1)
  ) u_mem (
    .clk     (Clock),
    .rst     (Reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (iDataIn),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (oDataOut)
  );

`ifdef FIFO_ERROR_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oOverflow  <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      if (iPush && oFull)  oOverflow  <= 1'b1;
      if (iPop  && oEmpty) oUnderflow <= 1'b1;
    end
  end
`else
  assign oOverflow  = 1'b0;
  assign oUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_dual_port_fifo.sv
// Self-checking bench for dual_port_fifo: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_dual_port_fifo;

  localparam int DW = 6;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;
`ifdef FIFO_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          iPush = 1'b0;
  logic          iPop = 1'b0;
  logic [DW-1:0] iDataIn = '0;
  logic [DW-1:0] oDataOut;
  logic          oValid;
  logic [AW:0]   oCount;
  logic          oFull, oEmpty, oAlmostFull, oAlmostEmpty, oOverflow, oUnderflow;

  dual_port_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iPush(iPush), .iPop(iPop), .iDataIn(iDataIn),
    .oDataOut(oDataOut), .oValid(oValid), .oCount(oCount), .oFull(oFull),
    .oEmpty(oEmpty), .oAlmostFull(oAlmostFull), .oAlmostEmpty(oAlmostEmpty),
    .oOverflow(oOverflow), .oUnderflow(oUnderflow)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;

  // Reference model: a plain queue of stored words plus output registers.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  typedef struct {
    bit push; bit pop; logic [DW-1:0] din;
    bit valid; logic [DW-1:0] dout; int count;
    bit full; bit empty; bit af; bit ae;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(bit p, bit o, logic [DW-1:0] d, bit v, logic [DW-1:0] od,
                              int c, bit f, bit e, bit afl, bit ael);
    vec_t r;
    r.push = p; r.pop = o; r.din = d; r.valid = v; r.dout = od; r.count = c;
    r.full = f; r.empty = e; r.af = afl; r.ae = ael;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit p, input bit o, input logic [DW-1:0] d);
    bit was_full, was_empty;
    if (rst) begin
      q.delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (ERR_EN && p && was_full)  m_ovf = 1'b1;
    if (ERR_EN && o && was_empty) m_udf = 1'b1;
    m_valid = o && !was_empty;
    if (m_valid) m_dout = q.pop_front();
    if (p && !was_full) q.push_back(d);
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("m_count", 32'(oCount), n);
    chk("m_full", 32'(oFull), 32'(n == DEPTH));
    chk("m_empty", 32'(oEmpty), 32'(n == 0));
    chk("m_afull", 32'(oAlmostFull), 32'(n >= AF));
    chk("m_aempty", 32'(oAlmostEmpty), 32'(n <= AE));
    chk("m_valid", 32'(oValid), 32'(m_valid));
    chk("m_dout", 32'(oDataOut), 32'(m_dout));
    chk("m_ovf", 32'(oOverflow), 32'(m_ovf));
    chk("m_udf", 32'(oUnderflow), 32'(m_udf));
  endtask

  task automatic cycle(input bit rst, input bit p, input bit o, input logic [DW-1:0] d);
    Reset = rst; iPush = p; iPop = o; iDataIn = d;
    @(posedge Clock);
    model_step(rst, p, o, d);
    #1;
    check_model();
  endtask

  initial begin
    int vcnt;
    logic [DW-1:0] d;
    int pw;

    // Fill 0x01..0x08 then drain, one idle cycle to see oValid drop.
    vecs.push_back(mk(1, 0, 6'h01, 0, 6'h00, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 6'h02, 0, 6'h00, 2, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 6'h03, 0, 6'h00, 3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 6'h04, 0, 6'h00, 4, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 6'h05, 0, 6'h00, 5, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 6'h06, 0, 6'h00, 6, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 6'h07, 0, 6'h00, 7, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 6'h08, 0, 6'h00, 8, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 6'h00, 1, 6'h01, 7, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 6'h00, 1, 6'h02, 6, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 6'h00, 1, 6'h03, 5, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 6'h00, 1, 6'h04, 4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 6'h00, 1, 6'h05, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 6'h00, 1, 6'h06, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 6'h00, 1, 6'h07, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 6'h00, 1, 6'h08, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 6'h00, 0, 6'h08, 0, 0, 1, 0, 1));

    // Reset held for two cycles.
    cycle(1, 0, 0, '0);
    cycle(1, 1, 1, 6'h15);
    Reset = 1'b0;
    chk("rst_empty", 32'(oEmpty), 1);
    chk("rst_aempty", 32'(oAlmostEmpty), 1);
    chk("rst_count", 32'(oCount), 0);
    chk("rst_valid", 32'(oValid), 0);
    chk("rst_dout", 32'(oDataOut), 0);
    chk("rst_full", 32'(oFull), 0);
    chk("rst_afull", 32'(oAlmostFull), 0);

    vcnt = 0;
    foreach (vecs[i]) begin
      cycle(0, vecs[i].push, vecs[i].pop, vecs[i].din);
      if (oValid === 1'b1) vcnt++;
      chk($sformatf("vec%0d_valid", i), 32'(oValid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_dout", i), 32'(oDataOut), 32'(vecs[i].dout));
      chk($sformatf("vec%0d_count", i), 32'(oCount), vecs[i].count);
      chk($sformatf("vec%0d_full", i), 32'(oFull), 32'(vecs[i].full));
      chk($sformatf("vec%0d_empty", i), 32'(oEmpty), 32'(vecs[i].empty));
      chk($sformatf("vec%0d_af", i), 32'(oAlmostFull), 32'(vecs[i].af));
      chk($sformatf("vec%0d_ae", i), 32'(oAlmostEmpty), 32'(vecs[i].ae));
    end
    chk("drain_valid_cycles", vcnt, 8);

    // Overflow: push 0x3F into a full FIFO while popping.
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 6'(8'h10 + i));
    chk("ovf_full", 32'(oFull), 1);
    cycle(0, 1, 1, 6'h3F);
    chk("ovf_valid", 32'(oValid), 1);
    chk("ovf_dout", 32'(oDataOut), 32'h10);
    chk("ovf_count", 32'(oCount), 7);
    chk("ovf_flag", 32'(oOverflow), 32'(ERR_EN));
    cycle(0, 0, 0, '0);
    chk("ovf_sticky", 32'(oOverflow), 32'(ERR_EN));
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, '0);
    chk("ovf_last_dout", 32'(oDataOut), 32'h17);
    chk("ovf_drained", 32'(oEmpty), 1);

    // Underflow: pop while empty.
    cycle(0, 0, 1, '0);
    chk("udf_valid", 32'(oValid), 0);
    chk("udf_dout_held", 32'(oDataOut), 32'h17);
    chk("udf_count", 32'(oCount), 0);
    chk("udf_flag", 32'(oUnderflow), 32'(ERR_EN));

    // Wrap-around at steady count 3.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 6'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 1, 6'(8'h23 + i));
      chk($sformatf("wrap%0d_count", i), 32'(oCount), 3);
      chk($sformatf("wrap%0d_dout", i), 32'(oDataOut), 32'(6'(8'h20 + i)));
    end

    // Reset in the same cycle as a push with count 5.
    cycle(0, 1, 0, 6'h30);
    cycle(0, 1, 0, 6'h31);
    chk("pre_rst_count", 32'(oCount), 5);
    cycle(1, 1, 0, 6'h2A);
    chk("midrst_count", 32'(oCount), 0);
    chk("midrst_empty", 32'(oEmpty), 1);
    chk("midrst_ovf", 32'(oOverflow), 0);
    chk("midrst_udf", 32'(oUnderflow), 0);
    cycle(0, 0, 1, '0);
    chk("midrst_pop_valid", 32'(oValid), 0);
    chk("midrst_pop_count", 32'(oCount), 0);

    // Random traffic; push bias changes every 100 cycles to reach full and empty.
    for (int blk = 0; blk < 6; blk++) begin
      pw = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 20 : 50);
      for (int i = 0; i < 100; i++) begin
        d = 6'($urandom);
        cycle($urandom_range(0, 149) == 0,
              $urandom_range(0, 99) < pw,
              $urandom_range(0, 99) < (100 - pw),
              d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
